// File: rtl/sync_fifo_wr_arb.sv
// Round-robin burst arbiter sharing one sync FIFO write port among NREQ producers.
// Grants are gated by FIFO free space; beats are gated by the FIFO full flag.
module sync_fifo_wr_arb #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int BURST    = 4,
  parameter int MIN_FREE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_last,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      fifo_full,
  input  logic [$clog2(DEPTH):0]    fifo_used_cnt,
  output logic                      fifo_wr,
  output logic [WIDTH-1:0]          fifo_din,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [BW-1:0]   beat_q, beat_d;

  logic [CW-1:0]   free;
  logic            start_ok;
  logic            found;
  logic [IW-1:0]   pick;
  logic [BW-1:0]   beat_inc;
  int              idx;

  assign free     = CW'(DEPTH) - fifo_used_cnt;
  assign start_ok = free >= CW'(MIN_FREE);
  assign beat_inc = beat_q + BW'(1);

  // First valid requester after the last owner, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    fifo_wr   = 1'b0;
    fifo_din  = req_data[int'(owner_q)*WIDTH +: WIDTH];
    if (state_q == GRANT) begin
      req_ready[owner_q] = !fifo_full;
      fifo_wr = req_valid[owner_q] & !fifo_full;
    end
  end

  assign grant_id = owner_q;
  assign busy     = (state_q == GRANT);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (found && start_ok) begin
          state_d = GRANT;
          owner_d = pick;
          rr_d    = pick;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (!req_valid[owner_q]) begin
          state_d = IDLE;
        end else if (fifo_wr) begin
          beat_d = beat_inc;
          if (req_last[owner_q] || beat_inc == BW'(BURST))
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= IW'(NREQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Bench for sync_fifo_wr_arb: queue-based FIFO and grant model, vector table,
// directed corner sequences and randomized traffic.
module tb_sync_fifo_wr_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int BURST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic [3:0]  a_valid, a_last, a_ready;
  logic [31:0] a_data;
  logic        a_full, a_wr, a_busy;
  logic [3:0]  a_used;
  logic [7:0]  a_din;
  logic [1:0]  a_gid;

  logic [3:0]  b_valid, b_last, b_ready;
  logic [31:0] b_data;
  logic        b_full, b_wr, b_busy;
  logic [3:0]  b_used;
  logic [7:0]  b_din;
  logic [1:0]  b_gid;

  sync_fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH),
    .BURST(BURST), .MIN_FREE(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_valid), .req_last(a_last), .req_data(a_data),
    .req_ready(a_ready), .fifo_full(a_full), .fifo_used_cnt(a_used),
    .fifo_wr(a_wr), .fifo_din(a_din), .grant_id(a_gid), .busy(a_busy));

  sync_fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH),
    .BURST(BURST), .MIN_FREE(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_valid), .req_last(b_last), .req_data(b_data),
    .req_ready(b_ready), .fifo_full(b_full), .fifo_used_cnt(b_used),
    .fifo_wr(b_wr), .fifo_din(b_din), .grant_id(b_gid), .busy(b_busy));

  int nchk = 0;
  int nerr = 0;

  logic [7:0] fq[$];
  logic [1:0] gq[$];
  logic       rd_en;
  int         wr_cnt, max_used, cyc;
  logic [9:0] wr_hist;

  logic       m_busy;
  int         m_owner, m_rr, m_beats;
  logic       s_wr;
  logic [7:0] s_din;
  logic [1:0] s_gid;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic [3:0] used;
    logic       full;
    logic       busy;
    logic [3:0] ready;
    logic       wr;
    logic [1:0] gid;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pick_next();
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_rr + k) % NREQ;
      if (a_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_rr    = NREQ - 1;
    m_beats = 0;
  endtask

  task automatic drive_fifo();
    a_used = 4'(fq.size());
    a_full = (fq.size() == DEPTH);
  endtask

  task automatic step();
    logic [3:0] er;
    logic       ew;
    int         p;
    @(negedge clk);
    ew = m_busy && a_valid[m_owner] && !a_full;
    er = (m_busy && !a_full) ? 4'(1 << m_owner) : 4'b0;
    chk("busy", 32'(a_busy), 32'(m_busy));
    chk("grant_id", 32'(a_gid), 32'(m_owner));
    chk("req_ready", 32'(a_ready), 32'(er));
    chk("fifo_wr", 32'(a_wr), 32'(ew));
    if (ew) chk("fifo_din", 32'(a_din), 32'(a_data[m_owner*8 +: 8]));
    s_wr  = a_wr;
    s_din = a_din;
    s_gid = a_gid;
    @(posedge clk);
    if (!m_busy) begin
      if (a_valid != 4'b0 && (DEPTH - int'(a_used)) >= 1) begin
        p = pick_next();
        m_busy  = 1'b1;
        m_owner = p;
        m_rr    = p;
        m_beats = 0;
      end
    end else if (!a_valid[m_owner]) begin
      m_busy = 1'b0;
    end else if (ew) begin
      m_beats++;
      if (a_last[m_owner] || m_beats == BURST) m_busy = 1'b0;
    end
    if (rd_en && fq.size() > 0) void'(fq.pop_front());
    if (s_wr) begin
      fq.push_back(s_din);
      wr_cnt++;
    end
    if (fq.size() > max_used) max_used = fq.size();
    if (cyc < 10) wr_hist[cyc] = s_wr;
    cyc++;
    #1;
    drive_fifo();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    a_valid = '0;
    a_last  = '0;
    rd_en   = 1'b0;
    b_valid = '0;
    b_last  = '0;
    b_full  = 1'b0;
    b_used  = '0;
    m_reset();
    fq.delete();
    drive_fifo();
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    wr_cnt = 0;
    max_used = 0;
  endtask

  initial begin
    a_data = 32'h0;
    b_data = 32'hA3A2A1A0;
    vt[0]  = '{4'b0100, 4'b0000, 4'd6, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    vt[1]  = '{4'b0100, 4'b0000, 4'd6, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    vt[2]  = '{4'b0100, 4'b0000, 4'd4, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    vt[3]  = '{4'b0100, 4'b0100, 4'd4, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};
    vt[4]  = '{4'b0100, 4'b0000, 4'd5, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2};
    vt[5]  = '{4'b0100, 4'b0000, 4'd8, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd2};
    vt[6]  = '{4'b0000, 4'b0000, 4'd8, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd2};
    vt[7]  = '{4'b1010, 4'b0000, 4'd8, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2};
    vt[8]  = '{4'b1010, 4'b0000, 4'd2, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2};
    vt[9]  = '{4'b1010, 4'b1000, 4'd2, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3};
    vt[10] = '{4'b1010, 4'b0000, 4'd2, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3};
    vt[11] = '{4'b0010, 4'b0010, 4'd2, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
    vt[12] = '{4'b0000, 4'b0000, 4'd2, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1};
    cyc = 100;

    // Reset state
    do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_wr", 32'(a_wr), 32'd0);
    chk("rst_gid", 32'(a_gid), 32'd0);
    do_reset();

    // MIN_FREE=3 vector table on the second instance
    for (int i = 0; i < 13; i++) begin
      b_valid = vt[i].valid;
      b_last  = vt[i].last;
      b_used  = vt[i].used;
      b_full  = vt[i].full;
      @(negedge clk);
      chk($sformatf("vec%0d_busy", i), 32'(b_busy), 32'(vt[i].busy));
      chk($sformatf("vec%0d_ready", i), 32'(b_ready), 32'(vt[i].ready));
      chk($sformatf("vec%0d_wr", i), 32'(b_wr), 32'(vt[i].wr));
      chk($sformatf("vec%0d_gid", i), 32'(b_gid), 32'(vt[i].gid));
      if (vt[i].wr) chk($sformatf("vec%0d_din", i), 32'(b_din),
                        32'(8'hA0 + 8'(vt[i].gid)));
      @(posedge clk);
      #1;
    end

    // Burst split: six beats, BURST=4
    do_reset();
    cyc = 0;
    wr_hist = '0;
    for (int i = 0; i < 10; i++) begin
      a_valid = (wr_cnt < 6) ? 4'b0001 : 4'b0000;
      a_data  = {24'h0, 8'hD0 + 8'(wr_cnt)};
      step();
    end
    chk("split_hist", 32'(wr_hist), 32'h0DE);
    chk("split_count", 32'(fq.size()), 32'd6);
    for (int i = 0; i < 6 && i < fq.size(); i++)
      chk($sformatf("split_data%0d", i), 32'(fq[i]), 32'(8'hD0 + 8'(i)));

    // Round robin, last on every beat
    do_reset();
    gq.delete();
    rd_en   = 1'b1;
    a_valid = 4'hF;
    a_last  = 4'hF;
    a_data  = 32'h33221100;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_wr) gq.push_back(s_gid);
    end
    chk("rr_grants", 32'(gq.size()), 32'd6);
    for (int i = 0; i < 6 && i < gq.size(); i++)
      chk($sformatf("rr_seq%0d", i), 32'(gq[i]), 32'(i % 4));

    // Full backpressure with 7 entries pre-filled
    do_reset();
    for (int i = 0; i < 7; i++) fq.push_back(8'h70 + 8'(i));
    drive_fifo();
    for (int i = 0; i < 20; i++) begin
      a_valid = (wr_cnt < 3) ? 4'b0010 : 4'b0000;
      a_data  = {16'h0, 8'hB0 + 8'(wr_cnt), 8'h0};
      rd_en   = (i == 5 || i == 9);
      step();
    end
    chk("bp_writes", 32'(wr_cnt), 32'd3);
    chk("bp_max_used", 32'(max_used <= DEPTH), 32'd1);
    chk("bp_size", 32'(fq.size()), 32'd8);
    if (fq.size() == 8) begin
      chk("bp_b0", 32'(fq[5]), 32'hB0);
      chk("bp_b1", 32'(fq[6]), 32'hB1);
      chk("bp_b2", 32'(fq[7]), 32'hB2);
    end

    // Early end on last
    do_reset();
    rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_valid = (wr_cnt < 2) ? 4'b1000 : 4'b0000;
      a_last  = (wr_cnt == 1) ? 4'b1000 : 4'b0000;
      a_data  = {8'hE0 + 8'(wr_cnt), 24'h0};
      step();
    end
    chk("early_writes", 32'(wr_cnt), 32'd2);
    chk("early_gid", 32'(a_gid), 32'd3);
    chk("early_busy", 32'(a_busy), 32'd0);

    // Reset during beat 2 of a req0 burst
    do_reset();
    rd_en   = 1'b1;
    a_valid = 4'b0001;
    for (int i = 0; i < 10 && wr_cnt < 1; i++) begin
      a_data = {24'h0, 8'hC0 + 8'(wr_cnt)};
      step();
    end
    a_data = 32'hC1;
    chk("mid_wr_before", 32'(a_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_wr_rst", 32'(a_wr), 32'd0);
    chk("mid_ready_rst", 32'(a_ready), 32'd0);
    chk("mid_busy_rst", 32'(a_busy), 32'd0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    a_valid = 4'b0011;
    step();
    chk("regrant_gid", 32'(a_gid), 32'd0);
    chk("regrant_busy", 32'(a_busy), 32'd1);
    step();
    a_valid = 4'b0000;
    step();
    step();

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      a_valid = 4'($urandom) | 4'($urandom);
      a_last  = 4'($urandom) & 4'($urandom);
      a_data  = $urandom;
      rd_en   = 1'($urandom_range(0, 1));
      step();
    end
    chk("rand_max_used", 32'(max_used <= DEPTH), 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
